// File: rtl/pcs_pkg.sv
// Shared constants and types for the 64b/66b transmit PCS encoder.
package pcs_pkg;

  localparam int unsigned PCS_PAYLOAD_W = 64;

  // Sync headers
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Block type bytes
  localparam logic [7:0] BT_IDLE = 8'h1E;
  localparam logic [7:0] BT_S0   = 8'h78;
  localparam logic [7:0] BT_S4   = 8'h33;
  localparam logic [7:0] BT_T0   = 8'h87;
  localparam logic [7:0] BT_T1   = 8'h99;
  localparam logic [7:0] BT_T2   = 8'hAA;
  localparam logic [7:0] BT_T3   = 8'hB4;
  localparam logic [7:0] BT_T4   = 8'hCC;
  localparam logic [7:0] BT_T5   = 8'hD2;
  localparam logic [7:0] BT_T6   = 8'hE1;
  localparam logic [7:0] BT_T7   = 8'hFF;

  // 7-bit control codes
  localparam logic [6:0] CC_IDLE = 7'h00;
  localparam logic [6:0] CC_ERR  = 7'h1E;

  // Kind of block being assembled, decided from the first beat
  typedef enum logic [2:0] {
    KIND_DATA = 3'd0,
    KIND_IDLE = 3'd1,
    KIND_S0   = 3'd2,
    KIND_S4   = 3'd3,
    KIND_TERM = 3'd4,
    KIND_ERR  = 3'd5
  } blk_kind_e;

  // One encoded 66-bit block
  typedef struct packed {
    logic [1:0]               head;
    logic [PCS_PAYLOAD_W-1:0] payload;
  } pcs_blk_t;

  // Terminate block type for k valid data bytes
  function automatic logic [7:0] term_type(input logic [2:0] k);
    logic [7:0] t;
    case (k)
      3'd0:    t = BT_T0;
      3'd1:    t = BT_T1;
      3'd2:    t = BT_T2;
      3'd3:    t = BT_T3;
      3'd4:    t = BT_T4;
      3'd5:    t = BT_T5;
      3'd6:    t = BT_T6;
      default: t = BT_T7;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pcs_tx_blk_enc.sv
// Combinational 64b/66b block encoder: kind + term length + raw bytes -> header and payload.
module pcs_tx_blk_enc
  import pcs_pkg::*;
(
  input  blk_kind_e   kind_i,
  input  logic [2:0]  tlen_i,
  input  logic [63:0] buf_i,
  output pcs_blk_t    blk_c
);

  // Build header and payload for the selected block kind
  always_comb begin
    blk_c.head    = SYNC_CTRL;
    blk_c.payload = '0;
    case (kind_i)
      KIND_DATA: begin
        blk_c.head    = SYNC_DATA;
        blk_c.payload = buf_i;
      end
      KIND_S0: begin
        // Input byte 0 is replaced by the type byte
        blk_c.payload = {buf_i[63:8], BT_S0};
      end
      KIND_S4: begin
        // Bytes 1..4 carry idle codes, frame starts at byte 5
        blk_c.payload = {buf_i[63:40], {4{8'(CC_IDLE)}}, BT_S4};
      end
      KIND_TERM: begin
        blk_c.payload[7:0] = term_type(tlen_i);
        for (int unsigned i = 0; i < 7; i++) begin
          if (3'(i) < tlen_i) begin
            blk_c.payload[(i+1)*8 +: 8] = buf_i[i*8 +: 8];
          end
        end
      end
      KIND_ERR: begin
        blk_c.payload = {{8{CC_ERR}}, BT_IDLE};
      end
      default: begin
        blk_c.payload = {56'h0, BT_IDLE};
      end
    endcase
  end

endmodule

// File: rtl/pcs_tx_enc.sv
// Transmit PCS encoder: gathers MAC beats into 64-bit blocks and emits registered 66-bit blocks.
module pcs_tx_enc
  import pcs_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BLOCK_W     = 64,
  parameter int unsigned BLOCK_N     = 8,
  parameter int unsigned BLOCK_LEN_W = $clog2(BLOCK_N + 1),
  parameter int unsigned LANE0_CNT_N = (DATA_W == 64) ? 2 : 1,
  parameter int unsigned BEAT_N      = BLOCK_W / DATA_W
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   ctrl_v_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic [LANE0_CNT_N-1:0] start_i,
  input  logic                   idle_i,
  input  logic                   term_i,
  input  logic [BLOCK_LEN_W-1:0] term_len_i,
  output logic                   ready_o,
  input  logic                   gb_ready_i,
  output logic                   block_v_o,
  output logic [1:0]             head_o,
  output logic [BLOCK_W-1:0]     data_o,
  output logic                   err_o
);

  localparam int unsigned CNT_W = (BEAT_N > 1) ? $clog2(BEAT_N) : 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  blk_kind_e          kind_q, kind_d;
  logic [2:0]         tlen_q, tlen_d;
  logic               block_v_q, block_v_d;
  logic               err_q, err_d;
  logic [1:0]         head_q, head_d;
  logic [BLOCK_W-1:0] data_q, data_d;

  logic               accept;
  logic               first_beat;
  logic               last_beat;
  logic [1:0]         start_w;
  logic [1:0]         flag_cnt;
  logic               err0;
  blk_kind_e          kind0;
  blk_kind_e          kind_cur;
  logic [2:0]         tlen_cur;
  logic [63:0]        enc_buf;
  pcs_blk_t           blk_c;

  // Beats are taken whenever the gearbox has room and we are out of reset
  assign ready_o    = gb_ready_i & ~nreset;
  assign accept     = ready_o;
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == CNT_W'(BEAT_N - 1));
  assign start_w    = 2'(start_i);
  assign flag_cnt   = 2'(|start_w) + 2'(term_i) + 2'(idle_i);

  // Classify the block from first-beat flags and fold in late start/term as errors
  always_comb begin
    err0 = (ctrl_v_i & (flag_cnt == 2'd0))
         | (term_len_i > BLOCK_LEN_W'(7))
         | (flag_cnt > 2'd1)
         | (&start_w)
         | ((LANE0_CNT_N == 1) & start_w[1]);

    if (err0)            kind0 = KIND_ERR;
    else if (start_w[0]) kind0 = KIND_S0;
    else if (start_w[1]) kind0 = KIND_S4;
    else if (term_i)     kind0 = KIND_TERM;
    else if (idle_i)     kind0 = KIND_IDLE;
    else                 kind0 = KIND_DATA;

    if (first_beat) begin
      kind_cur = kind0;
      tlen_cur = term_len_i[2:0];
    end else begin
      kind_cur = ((|start_w) | term_i) ? KIND_ERR : kind_q;
      tlen_cur = tlen_q;
    end

    // Buffer including the beat on the bus; used both for storage and final encode
    buf_d = buf_q;
    if (accept) begin
      for (int unsigned b = 0; b < BEAT_N; b++) begin
        if (cnt_q == CNT_W'(b)) begin
          buf_d[b*DATA_W +: DATA_W] = data_i;
        end
      end
    end
    enc_buf = 64'(buf_d);
  end

  pcs_tx_blk_enc u_blk_enc (
    .kind_i (kind_cur),
    .tlen_i (tlen_cur),
    .buf_i  (enc_buf),
    .blk_c  (blk_c)
  );

  // Beat counter, kind latch and output register update
  always_comb begin
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    tlen_d    = tlen_q;
    block_v_d = 1'b0;
    err_d     = 1'b0;
    head_d    = head_q;
    data_d    = data_q;
    if (accept) begin
      kind_d = kind_cur;
      tlen_d = tlen_cur;
      if (last_beat) begin
        cnt_d     = '0;
        block_v_d = 1'b1;
        err_d     = (kind_cur == KIND_ERR);
        head_d    = blk_c.head;
        data_d    = BLOCK_W'(blk_c.payload);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset; a partial block is dropped on reset
  always_ff @(posedge clk) begin
    if (nreset) begin
      cnt_q     <= '0;
      buf_q     <= '0;
      kind_q    <= KIND_IDLE;
      tlen_q    <= '0;
      block_v_q <= 1'b0;
      err_q     <= 1'b0;
      head_q    <= SYNC_CTRL;
      data_q    <= BLOCK_W'({56'h0, BT_IDLE});
    end else begin
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      kind_q    <= kind_d;
      tlen_q    <= tlen_d;
      block_v_q <= block_v_d;
      err_q     <= err_d;
      head_q    <= head_d;
      data_q    <= data_d;
    end
  end

  assign block_v_o = block_v_q;
  assign err_o     = err_q;
  assign head_o    = head_q;
  assign data_o    = data_q;

endmodule
